// File: rtl/sparc_pkg.sv
// Shared SPARC register-file definitions: window count default, register
// class ranges, physical index sizing and the window-operation encoding.
package sparc_pkg;

  localparam int unsigned NWINDOWS_DEFAULT = 8;

  localparam int unsigned GLOBAL_LO = 0;
  localparam int unsigned GLOBAL_HI = 7;
  localparam int unsigned OUT_LO    = 8;
  localparam int unsigned OUT_HI    = 15;
  localparam int unsigned LOCAL_LO  = 16;
  localparam int unsigned LOCAL_HI  = 23;
  localparam int unsigned IN_LO     = 24;
  localparam int unsigned IN_HI     = 31;

  localparam int unsigned NGLOBALS        = GLOBAL_HI - GLOBAL_LO + 1;
  localparam int unsigned REGS_PER_WINDOW = (OUT_HI - OUT_LO + 1) + (LOCAL_HI - LOCAL_LO + 1);

  typedef enum logic [1:0] {
    CLS_GLOBAL,
    CLS_OUT,
    CLS_LOCAL,
    CLS_IN
  } reg_class_e;

  typedef enum logic [1:0] {
    WOP_NONE,
    WOP_SAVE,
    WOP_RESTORE
  } win_op_e;

  function automatic int unsigned phys_idx_w(input int unsigned nwin);
    return $clog2(NGLOBALS + REGS_PER_WINDOW * nwin);
  endfunction

  localparam int unsigned PHYS_IDX_W = phys_idx_w(NWINDOWS_DEFAULT);

  function automatic reg_class_e reg_class(input logic [4:0] addr);
    if (32'(addr) <= GLOBAL_HI)     return CLS_GLOBAL;
    else if (32'(addr) <= OUT_HI)   return CLS_OUT;
    else if (32'(addr) <= LOCAL_HI) return CLS_LOCAL;
    else                            return CLS_IN;
  endfunction

endpackage

// File: rtl/reg_addr_map.sv
// Architectural register + current window pointer -> physical register index.
// Layout: globals at 0..7, then per window w: outs[w] (8) followed by locals[w] (8).
module reg_addr_map
  import sparc_pkg::*;
#(
  parameter int unsigned NWINDOWS = NWINDOWS_DEFAULT,
  parameter int unsigned CWP_W    = $clog2(NWINDOWS),
  parameter int unsigned PW       = phys_idx_w(NWINDOWS)
) (
  input  logic [4:0]       arch_addr,
  input  logic [CWP_W-1:0] cwp,
  output logic [PW-1:0]    phys_idx
);

  reg_class_e       cls;
  logic [CWP_W-1:0] win;
  logic [PW-1:0]    win_base;

  // Ins alias the outs of the next window; the CWP_W-bit add wraps modulo NWINDOWS.
  always_comb begin
    cls      = reg_class(arch_addr);
    win      = (cls == CLS_IN) ? cwp + CWP_W'(1) : cwp;
    win_base = PW'(NGLOBALS) + PW'({win, 4'b0000});
    unique case (cls)
      CLS_GLOBAL: phys_idx = PW'(arch_addr[2:0]);
      CLS_LOCAL:  phys_idx = win_base + PW'(8) + PW'(arch_addr[2:0]);
      default:    phys_idx = win_base + PW'(arch_addr[2:0]);
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// Windowed SPARC-style register file: two combinational read ports with
// write bypass, one write port, save/restore window shifting with WIM traps.
module reg_file
  import sparc_pkg::*;
#(
  parameter int unsigned NWINDOWS = NWINDOWS_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [4:0]                  wr_addr,
  input  logic [31:0]                 wr_data,
  input  logic [4:0]                  rd_addr_a,
  input  logic [4:0]                  rd_addr_b,
  output logic [31:0]                 rd_data_a,
  output logic [31:0]                 rd_data_b,
  input  logic                        save_req,
  input  logic                        restore_req,
  input  logic                        wim_wr_en,
  input  logic [NWINDOWS-1:0]         wim_data,
  output logic [$clog2(NWINDOWS)-1:0] cwp,
  output logic                        win_overflow,
  output logic                        win_underflow
);

  localparam int unsigned CWP_W = $clog2(NWINDOWS);
  localparam int unsigned PW    = phys_idx_w(NWINDOWS);
  localparam int unsigned NPHYS = NGLOBALS + REGS_PER_WINDOW * NWINDOWS;

  logic [31:0]         regs_q [NPHYS];
  logic [31:0]         regs_d [NPHYS];
  logic [CWP_W-1:0]    cwp_q, cwp_d, cwp_new;
  logic [NWINDOWS-1:0] wim_q, wim_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  win_op_e             win_op;

  logic [PW-1:0] idx_a, idx_b, idx_w;

  reg_addr_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PW(PW)) u_map_a (
    .arch_addr (rd_addr_a),
    .cwp       (cwp_q),
    .phys_idx  (idx_a)
  );

  reg_addr_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PW(PW)) u_map_b (
    .arch_addr (rd_addr_b),
    .cwp       (cwp_q),
    .phys_idx  (idx_b)
  );

  reg_addr_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PW(PW)) u_map_w (
    .arch_addr (wr_addr),
    .cwp       (cwp_q),
    .phys_idx  (idx_w)
  );

  // Read ports: r0 hardwired to zero, same-cycle write bypass, zero during reset.
  always_comb begin
    if (reset || rd_addr_a == '0)          rd_data_a = '0;
    else if (wr_en && wr_addr == rd_addr_a) rd_data_a = wr_data;
    else                                    rd_data_a = regs_q[idx_a];

    if (reset || rd_addr_b == '0)          rd_data_b = '0;
    else if (wr_en && wr_addr == rd_addr_b) rd_data_b = wr_data;
    else                                    rd_data_b = regs_q[idx_b];
  end

  // Next register contents: write decoded through the pre-update window.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && wr_addr != '0) regs_d[idx_w] = wr_data;
  end

  // Register array storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NPHYS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Window control: save/restore against the old WIM; simultaneous requests cancel.
  always_comb begin
    unique case ({save_req, restore_req})
      2'b10:   win_op = WOP_SAVE;
      2'b01:   win_op = WOP_RESTORE;
      default: win_op = WOP_NONE;
    endcase

    cwp_d   = cwp_q;
    cwp_new = cwp_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    wim_d   = wim_wr_en ? wim_data : wim_q;

    unique case (win_op)
      WOP_SAVE: begin
        cwp_new = cwp_q - CWP_W'(1);
        if (wim_q[cwp_new]) ovf_d = 1'b1;
        else                cwp_d = cwp_new;
      end
      WOP_RESTORE: begin
        cwp_new = cwp_q + CWP_W'(1);
        if (wim_q[cwp_new]) unf_d = 1'b1;
        else                unf_d = 1'b0;
        if (!wim_q[cwp_new]) cwp_d = cwp_new;
      end
      default: ;
    endcase
  end

  // Window pointer, invalid mask and registered trap pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      cwp_q <= '0;
      wim_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cwp_q <= cwp_d;
      wim_q <= wim_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign cwp           = cwp_q;
  assign win_overflow  = ovf_q;
  assign win_underflow = unf_q;

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter NWINDOWS, default 8, giving the number of register windows (power of two, 2..32).
REQ-002 SHALL have port clk  input  1  the single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wr_en  input  1  register write enable, driven by the writeback stage.
REQ-005 SHALL have port wr_addr  input  5  architectural destination register r0..r31.
REQ-006 SHALL have port wr_data  input  32  write data.
REQ-007 SHALL have ports rd_addr_a, rd_addr_b  input  5 each  architectural source registers.
REQ-008 SHALL have ports rd_data_a, rd_data_b  output  32 each  read data.
REQ-009 SHALL have ports save_req, restore_req  input  1 each  window-shift requests.
REQ-010 SHALL have ports wim_wr_en (input 1) and wim_data (input NWINDOWS), which load the window invalid mask.
REQ-011 SHALL have port cwp  output  log2(NWINDOWS)  current window pointer.
REQ-012 SHALL have ports win_overflow, win_underflow  output  1 each  one-cycle trap pulses.

Function
REQ-013 SHALL map r0-r7 to 8 shared globals, r8-r15 to outs[cwp], r16-r23 to locals[cwp], and r24-r31 to outs[(cwp+1) mod NWINDOWS].
REQ-014 SHALL hold 8 + 16*NWINDOWS physical 32-bit registers.
REQ-015 SHALL always read r0 as 0 and SHALL ignore writes to r0.
REQ-016 SHALL drive reads combinationally, with zero-cycle latency, using the registered cwp.
REQ-017 SHALL bypass a same-cycle write: if wr_en is high and wr_addr equals rd_addr (nonzero), rd_data SHALL equal wr_data.
REQ-018 SHALL commit the write on the clock edge, decoded with the pre-update cwp.
REQ-019 On save_req alone, SHALL set new = (cwp-1) mod NWINDOWS. If wim[new] is 1, SHALL leave cwp unchanged and pulse win_overflow for the next cycle; otherwise cwp SHALL become new.
REQ-020 On restore_req alone, SHALL set new = (cwp+1) mod NWINDOWS. If wim[new] is 1, SHALL leave cwp unchanged and pulse win_underflow; otherwise cwp SHALL become new.
REQ-021 SHALL wrap cwp modulo NWINDOWS in both directions (0 -> NWINDOWS-1 on save, NWINDOWS-1 -> 0 on restore).
REQ-022 If save_req and restore_req are asserted together, SHALL perform neither and raise no trap.
REQ-023 SHALL check a save/restore against the old wim when wim_wr_en occurs in the same cycle; the new wim SHALL take effect the following cycle.
REQ-024 SHALL hold win_overflow and win_underflow high for exactly one cycle per rejected request, never both in the same cycle.

Reset
REQ-025 While reset is high at a clock edge, SHALL clear all physical registers to 0, cwp to 0, wim to 0, and both trap outputs to 0.
REQ-026 Reset SHALL take priority over any same-cycle write, save, restore, or wim write.
REQ-027 During reset cycles, SHALL drive rd_data_a and rd_data_b as 0.

Structure
REQ-028 SHALL take NWINDOWS default, the register-class localparams (GLOBAL, OUT, LOCAL, IN ranges), and the physical-index width from the shared sparc_pkg.
REQ-029 SHALL use one sub-module, reg_addr_map, which converts (architectural address, cwp) to a physical index and is instantiated for each read port and the write port.

Verification
REQ-030 Reset, then write r5=0x44444444, and read r5 and r0 -> 0x44444444 and 0x00000000.
REQ-031 With cwp=0, write r8=0xA5A5A5A5, then save -> cwp=7 and r24 reads 0xA5A5A5A5; restore -> cwp=0 and r8 still reads 0xA5A5A5A5.
REQ-032 With wim=0x80 and cwp=0, assert save_req -> win_overflow high for 1 cycle and cwp stays 0; the same check with wim=0x02 and restore -> win_underflow.
REQ-033 Drive wr_en with r17=0x12345678 while rd_addr_a=17 in the same cycle -> rd_data_a=0x12345678 via bypass.
REQ-034 Write r16=0x1 in the same cycle as save_req, then restore -> r16 reads 0x1, confirming the write used the old cwp.
REQ-035 Assert save_req and restore_req together -> cwp unchanged and no trap; assert reset mid-sequence -> all reads 0 and cwp=0 on the next cycle.
